// File: rtl/ascon_msk_pkg.sv
// Shared definitions for the masked Ascon S-box layer controller and its helpers.
package ascon_msk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } layer_state_e;

  localparam int NCOL = 64;

  // Fresh random bits per masked S-box: one per AND-gadget share pair, five ANDs per column.
  function automatic int rnd_per_sbox(input int d);
    return 5 * d * (d - 1) / 2;
  endfunction

endpackage

// File: rtl/msk_sbox_layer_ctrl_if.sv
// Handshake bundle between the round FSM / PRNG / S-box array and the layer controller.
interface msk_sbox_layer_ctrl_if #(
  parameter int IW = 4
);

  logic          start;
  logic          busy;
  logic          done;
  logic          rnd_valid;
  logic          rnd_ready;
  logic          sb_in_valid;
  logic [IW-1:0] sb_in_idx;
  logic          sb_out_we;
  logic [IW-1:0] sb_out_idx;

  modport master (
    input  start,
    input  rnd_valid,
    output busy,
    output done,
    output rnd_ready,
    output sb_in_valid,
    output sb_in_idx,
    output sb_out_we,
    output sb_out_idx
  );

  modport slave (
    output start,
    output rnd_valid,
    input  busy,
    input  done,
    input  rnd_ready,
    input  sb_in_valid,
    input  sb_in_idx,
    input  sb_out_we,
    input  sb_out_idx
  );

endinterface

// File: rtl/msk_lat_pipe.sv
// Fixed-latency valid+index delay line that shadows a free-running gadget pipeline.
module msk_lat_pipe #(
  parameter int LAT = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   idx [LAT];

  // Never stalls: the gadget it tracks has no enable, so this must not have one either.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_idx   = idx[LAT-1];

endmodule

// File: rtl/msk_sbox_layer_ctrl.sv
// Sequences one masked Ascon substitution layer: issues column groups as randomness
// arrives and produces the matching write-back strobes LAT cycles later.
module msk_sbox_layer_ctrl #(
  parameter int D    = 2,
  parameter int PAR  = 4,
  parameter int LAT  = 2,
  parameter int NCOL = ascon_msk_pkg::NCOL
) (
  input logic                   clk,
  input logic                   rst,
  msk_sbox_layer_ctrl_if.master bus
);

  import ascon_msk_pkg::*;

  localparam int NG   = NCOL / PAR;
  localparam int IW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW   = IW + 1;
  localparam int RNDW = PAR * rnd_per_sbox(D);

  localparam logic [CW-1:0] LAST = CW'(NG - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  generate
    if ((NCOL % PAR) != 0 || LAT < 1 || RNDW < 1) begin : g_bad_cfg
      $error("msk_sbox_layer_ctrl: PAR must divide NCOL, LAT >= 1, D >= 2");
    end
  endgenerate

  layer_state_e  state_q;
  layer_state_e  state_d;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] write_cnt;

  logic          busy;
  logic          done;
  logic          rnd_ready;
  logic          in_valid;
  logic [IW-1:0] in_idx;
  logic          out_we;
  logic [IW-1:0] out_idx;

  // Counters are cleared when a layer is accepted so a new layer never inherits stale counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      issue_cnt <= '0;
      write_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        issue_cnt <= '0;
        write_cnt <= '0;
      end else begin
        if (in_valid) begin
          issue_cnt <= issue_cnt + ONE;
        end
        if (out_we && state_q != IDLE) begin
          write_cnt <= write_cnt + ONE;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    rnd_ready = 1'b0;
    in_valid  = 1'b0;
    in_idx    = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rnd_ready = 1'b1;
        in_valid  = bus.rnd_valid;
        in_idx    = issue_cnt[IW-1:0];
        if (bus.rnd_valid && issue_cnt == LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last write can only land here, since it trails the last issue by LAT >= 1.
        if (out_we && write_cnt == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  msk_lat_pipe #(
    .LAT (LAT),
    .W   (IW)
  ) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_idx    (in_idx),
    .out_valid (out_we),
    .out_idx   (out_idx)
  );

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.rnd_ready   = rnd_ready;
  assign bus.sb_in_valid = in_valid;
  assign bus.sb_in_idx   = in_idx;
  assign bus.sb_out_we   = out_we;
  assign bus.sb_out_idx  = out_idx;

endmodule

// File: tb/tb_msk_sbox_layer_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed issue/write/done events, monitors pop them.
module tb_msk_sbox_layer_ctrl;

  localparam int NG  = 16;
  localparam int LAT = 2;

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ev_t in_q[$];
  ev_t out_q[$];
  int  done_q[$];
  ev_t in64_q[$];
  ev_t out64_q[$];
  int  done64_q[$];
  ev_t ev_a;
  ev_t ev_b;

  msk_sbox_layer_ctrl_if #(.IW(4)) bus ();
  msk_sbox_layer_ctrl_if #(.IW(1)) bus64 ();

  msk_sbox_layer_ctrl #(.D(2), .PAR(4), .LAT(2), .NCOL(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  msk_sbox_layer_ctrl #(.D(2), .PAR(64), .LAT(2), .NCOL(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rv);
    @(posedge clk);
    #1;
    bus.start     = s;
    bus.rnd_valid = rv;
  endtask

  // A gap-free layer whose first transfer lands in cycle 'first'.
  task automatic pushLayer(input int first);
    for (int i = 0; i < NG; i++) begin
      in_q.push_back('{first + i, i});
      out_q.push_back('{first + LAT + i, i});
    end
    done_q.push_back(first + NG + LAT);
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_issues_missing"}, in_q.size(), 0);
    checkOutput({tag, "_writes_missing"}, out_q.size(), 0);
    checkOutput({tag, "_done_missing"}, done_q.size(), 0);
    in_q.delete();
    out_q.delete();
    done_q.delete();
  endtask

  always @(negedge clk) begin
    if (bus.sb_in_valid === 1'b1) begin
      if (in_q.size() == 0) begin
        checkOutput("unexpected_issue", bus.sb_in_valid, 0);
      end else begin
        ev_a = in_q.pop_front();
        checkOutput("issue_cycle", cyc, ev_a.cyc);
        checkOutput("issue_idx", 32'(bus.sb_in_idx), ev_a.idx);
      end
    end
    if (bus.sb_out_we === 1'b1) begin
      if (out_q.size() == 0) begin
        checkOutput("unexpected_write", bus.sb_out_we, 0);
      end else begin
        ev_a = out_q.pop_front();
        checkOutput("write_cycle", cyc, ev_a.cyc);
        checkOutput("write_idx", 32'(bus.sb_out_idx), ev_a.idx);
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        checkOutput("unexpected_done", bus.done, 0);
      end else begin
        checkOutput("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus64.sb_in_valid === 1'b1) begin
      if (in64_q.size() == 0) begin
        checkOutput("unexpected_issue64", bus64.sb_in_valid, 0);
      end else begin
        ev_b = in64_q.pop_front();
        checkOutput("issue64_cycle", cyc, ev_b.cyc);
        checkOutput("issue64_idx", 32'(bus64.sb_in_idx), ev_b.idx);
      end
    end
    if (bus64.sb_out_we === 1'b1) begin
      if (out64_q.size() == 0) begin
        checkOutput("unexpected_write64", bus64.sb_out_we, 0);
      end else begin
        ev_b = out64_q.pop_front();
        checkOutput("write64_cycle", cyc, ev_b.cyc);
        checkOutput("write64_idx", 32'(bus64.sb_out_idx), ev_b.idx);
      end
    end
    if (bus64.done === 1'b1) begin
      if (done64_q.size() == 0) begin
        checkOutput("unexpected_done64", bus64.done, 0);
      end else begin
        checkOutput("done64_cycle", cyc, done64_q.pop_front());
      end
    end
  end

  initial begin
    int b;
    int bad_busy;
    int bad_ready;

    bus.start       = 1'b0;
    bus.rnd_valid   = 1'b1;
    bus64.start     = 1'b0;
    bus64.rnd_valid = 1'b0;

    // Reset values, with randomness offered during reset.
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_rnd_ready", bus.rnd_ready, 0);
    checkOutput("rst_sb_in_valid", bus.sb_in_valid, 0);
    checkOutput("rst_sb_in_idx", 32'(bus.sb_in_idx), 0);
    checkOutput("rst_sb_out_we", bus.sb_out_we, 0);
    checkOutput("rst_sb_out_idx", 32'(bus.sb_out_idx), 0);
    rst = 1'b0;
    applyStimulus(0, 1);

    $display("[TB] layer with rnd_valid tied high");
    applyStimulus(1, 1);
    b = cyc;
    pushLayer(b + 1);
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(0, 1);
      if (k == 1) begin
        checkOutput("t1_busy_issue", bus.busy, 1);
        checkOutput("t1_rnd_ready_issue", bus.rnd_ready, 1);
      end
      if (k == 19) checkOutput("t1_busy_done", bus.busy, 1);
      if (k == 20) checkOutput("t1_busy_after", bus.busy, 0);
    end
    checkDrained("t1");

    $display("[TB] rnd_valid toggling");
    applyStimulus(1, 0);
    b = cyc;
    for (int i = 0; i < NG; i++) begin
      in_q.push_back('{b + 1 + 2 * i, i});
      out_q.push_back('{b + 1 + LAT + 2 * i, i});
    end
    done_q.push_back(b + 34);
    for (int k = 1; k <= 38; k++) begin
      applyStimulus(0, (k % 2) == 1);
      if (k == 2) checkOutput("t2_rnd_ready_bubble", bus.rnd_ready, 1);
      if (k == 33) checkOutput("t2_rnd_ready_drain", bus.rnd_ready, 0);
    end
    checkDrained("t2");

    $display("[TB] start while busy and in DONE");
    applyStimulus(1, 1);
    b = cyc;
    pushLayer(b + 1);
    for (int k = 1; k <= 42; k++) begin
      applyStimulus(k == 5 || k == 19 || k == 21, 1);
      if (k == 19) checkOutput("t3_busy_done", bus.busy, 1);
      if (k == 20) checkOutput("t3_busy_after_done", bus.busy, 0);
      if (k == 21) pushLayer(b + 22);
    end
    checkDrained("t3");

    $display("[TB] reset mid-layer");
    applyStimulus(1, 1);
    b = cyc;
    for (int i = 0; i < 10; i++) in_q.push_back('{b + 1 + i, i});
    for (int i = 0; i < 8; i++) out_q.push_back('{b + 1 + LAT + i, i});
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 1);
      rst = (k == 10);
      if (k == 11) begin
        checkOutput("t4_busy", bus.busy, 0);
        checkOutput("t4_rnd_ready", bus.rnd_ready, 0);
        checkOutput("t4_sb_out_we", bus.sb_out_we, 0);
      end
      if (k == 12) checkOutput("t4_sb_out_we_late", bus.sb_out_we, 0);
    end
    rst = 1'b0;
    checkDrained("t4");

    $display("[TB] randomness starved for 100 cycles");
    applyStimulus(1, 0);
    b = cyc;
    bad_busy  = 0;
    bad_ready = 0;
    pushLayer(b + 101);
    for (int k = 1; k <= 122; k++) begin
      applyStimulus(0, k >= 101);
      if (k <= 100) begin
        if (bus.busy !== 1'b1) bad_busy++;
        if (bus.rnd_ready !== 1'b1) bad_ready++;
      end
    end
    checkOutput("t6_busy_starved_errors", bad_busy, 0);
    checkOutput("t6_rnd_ready_starved_errors", bad_ready, 0);
    checkDrained("t6");

    $display("[TB] single-group layer (PAR=64)");
    @(posedge clk);
    #1;
    bus64.start     = 1'b1;
    bus64.rnd_valid = 1'b1;
    b = cyc;
    in64_q.push_back('{b + 1, 0});
    out64_q.push_back('{b + 3, 0});
    done64_q.push_back(b + 4);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      bus64.start = 1'b0;
      if (k == 2) checkOutput("t5_rnd_ready_drain", bus64.rnd_ready, 0);
      if (k == 4) checkOutput("t5_busy_done", bus64.busy, 1);
      if (k == 5) checkOutput("t5_busy_after", bus64.busy, 0);
    end
    checkOutput("t5_issues_missing", in64_q.size(), 0);
    checkOutput("t5_writes_missing", out64_q.size(), 0);
    checkOutput("t5_done_missing", done64_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
